// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the writeback requesters / decode stage and the
// writeback arbiter.
//   master : requesters and decode (drive requests, issue info, source regs)
//   slave  : arbiter (drives ready, hazard flags and the RegisterFile write port)
// Signals:
//   req_valid/req_sel/req_data/req_ready : per-requester writeback handshake,
//                                          slice i of sel/data at [i*W +: W]
//   issue_valid/issue_rd/issue_stall     : decode issue and WAW refusal
//   rs1/rs2/rs1_busy/rs2_busy            : source hazard query
//   wen/wsel/wdata                       : registered RegisterFile write port
//   busy_mask                            : scoreboard contents
interface regfile_wb_arbiter_if #(
    parameter int NREQ = 2,
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_sel;
    logic [NREQ*XLEN-1:0] req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 issue_valid;
    logic [AW-1:0]        issue_rd;
    logic [AW-1:0]        rs1;
    logic [AW-1:0]        rs2;
    logic                 rs1_busy;
    logic                 rs2_busy;
    logic                 issue_stall;
    logic                 wen;
    logic [AW-1:0]        wsel;
    logic [XLEN-1:0]      wdata;
    logic [31:0]          busy_mask;

    modport master (
        output req_valid, req_sel, req_data, issue_valid, issue_rd, rs1, rs2,
        input  req_ready, rs1_busy, rs2_busy, issue_stall, wen, wsel, wdata, busy_mask
    );

    modport slave (
        input  req_valid, req_sel, req_data, issue_valid, issue_rd, rs1, rs2,
        output req_ready, rs1_busy, rs2_busy, issue_stall, wen, wsel, wdata, busy_mask
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter of NREQ writeback requesters onto the single
// RegisterFile write port, plus a 32-entry busy scoreboard for decode hazards.
// The write port is driven from a one-entry registered stage that is drained
// every cycle, so RegisterFile's negedge write sees stable values.
// Ports:
//   i_clk   : clock, all state updates on posedge
//   i_rst_n : asynchronous active-low reset
//   bus     : regfile_wb_arbiter_if.slave (handshake, hazard and write port)
// AW is expected to be 5 (32 architectural registers).
module regfile_wb_arbiter #(
    parameter int NREQ = 2,
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   r_ptr;
    logic            r_wen;
    logic [AW-1:0]   r_wsel;
    logic [XLEN-1:0] r_wdata;
    logic [31:0]     r_busy;

    logic            w_found;
    logic [PW-1:0]   w_gidx;
    logic [NREQ-1:0] w_grant;
    logic [AW-1:0]   w_gsel;
    logic [XLEN-1:0] w_gdata;
    logic            w_transfer;
    logic            w_issueOk;
    logic [31:0]     w_clrMask;
    logic [31:0]     w_setMask;

    // First valid requester found when scanning upward from the pointer.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && bus.req_valid[(int'(r_ptr) + k) % NREQ]) begin
                w_found = 1'b1;
                w_gidx  = PW'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    // Ready is forced low during reset so no requester believes it transferred.
    always_comb begin
        w_grant = '0;
        if (w_found && i_rst_n) begin
            w_grant[w_gidx] = 1'b1;
        end
    end

    // Mux the granted requester's destination and data.
    always_comb begin
        w_gsel  = '0;
        w_gdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gidx == PW'(i)) begin
                w_gsel  = bus.req_sel[i*AW +: AW];
                w_gdata = bus.req_data[i*XLEN +: XLEN];
            end
        end
    end

    assign w_transfer = w_found && i_rst_n;

    // The register being committed this cycle is written at the negedge, so
    // it no longer counts as a hazard for issue or for source reads.
    assign bus.issue_stall = bus.issue_valid && (bus.issue_rd != '0) &&
                             r_busy[bus.issue_rd] &&
                             !(r_wen && (r_wsel == bus.issue_rd));
    assign bus.rs1_busy    = (bus.rs1 != '0) && r_busy[bus.rs1] &&
                             !(r_wen && (r_wsel == bus.rs1));
    assign bus.rs2_busy    = (bus.rs2 != '0) && r_busy[bus.rs2] &&
                             !(r_wen && (r_wsel == bus.rs2));

    assign w_issueOk = bus.issue_valid && !bus.issue_stall && (bus.issue_rd != '0);
    assign w_clrMask = r_wen     ? (32'd1 << r_wsel)       : 32'd0;
    assign w_setMask = w_issueOk ? (32'd1 << bus.issue_rd) : 32'd0;

    // Pointer advances past the winner only on an actual transfer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (w_transfer) begin
            r_ptr <= (w_gidx == PW'(NREQ - 1)) ? '0 : w_gidx + PW'(1);
        end
    end

    // Writeback stage: loads on every transfer, drains itself otherwise.
    // An x0 transfer is consumed but never raises wen, and the stage keeps
    // its previous select/data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wen   <= 1'b0;
            r_wsel  <= '0;
            r_wdata <= '0;
        end else if (w_transfer && (w_gsel != '0)) begin
            r_wen   <= 1'b1;
            r_wsel  <= w_gsel;
            r_wdata <= w_gdata;
        end else begin
            r_wen   <= 1'b0;
        end
    end

    // Scoreboard: clear on commit, then set on issue so a new producer of the
    // same register stays outstanding. Bit 0 never holds a hazard.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= ((r_busy & ~w_clrMask) | w_setMask) & ~32'd1;
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.wen       = r_wen;
    assign bus.wsel      = r_wsel;
    assign bus.wdata     = r_wdata;
    assign bus.busy_mask = r_busy;

endmodule
